// File: rtl/ov_fifo_wr_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// ov_fifo_wr_ctrl_pkg
// Shared definitions for the AL422B write-side controller: FSM state encoding
// (3-bit, also used by camera_ctrl when naming the handshake phases), default
// timing constants and a small state-classification helper.
// ----------------------------------------------------------------------------
package ov_fifo_wr_ctrl_pkg;

    // Default timing / sizing values
    localparam int WRST_CYCLES_DEF    = 32'd4;
    localparam int TIMEOUT_CYCLES_DEF = 32'd2_000_000;
    localparam int CNT_W_DEF          = 32'd16;

    // Write-controller states
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ARM   = 3'd1,
        ST_WRST  = 3'd2,
        ST_SYNC  = 3'd3,
        ST_WRITE = 3'd4,
        ST_DONE  = 3'd5
    } wr_state_e;

    // States in which we are waiting on the camera and can time out
    function automatic logic is_timed_state(input wr_state_e st);
        return (st == ST_ARM) || (st == ST_SYNC) || (st == ST_WRITE);
    endfunction

endpackage

// File: rtl/ov_fifo_wr_ctrl_if.sv
// ----------------------------------------------------------------------------
// ov_fifo_wr_ctrl_if
// Bundles the camera VSYNC pin, the reader handshake and the FIFO write-side
// controls of ov_fifo_wr_ctrl.
//   master : the write controller (drives fifo_wen/fifo_wrst/status)
//   slave  : the surroundings (camera pin, reader, FIFO)
// Signals: ov_vsync, frame_req, frame_done (to controller);
//          fifo_wen, fifo_wrst (active low), frame_ready, busy,
//          frame_cnt[CNT_W], timeout_err (from controller).
// ----------------------------------------------------------------------------
interface ov_fifo_wr_ctrl_if
    import ov_fifo_wr_ctrl_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
);
    logic             ov_vsync;
    logic             frame_req;
    logic             frame_done;
    logic             fifo_wen;
    logic             fifo_wrst;
    logic             frame_ready;
    logic             busy;
    logic [CNT_W-1:0] frame_cnt;
    logic             timeout_err;

    modport master (
        input  ov_vsync, frame_req, frame_done,
        output fifo_wen, fifo_wrst, frame_ready, busy, frame_cnt, timeout_err
    );

    modport slave (
        output ov_vsync, frame_req, frame_done,
        input  fifo_wen, fifo_wrst, frame_ready, busy, frame_cnt, timeout_err
    );
endinterface

// File: rtl/ov_fifo_wr_ctrl_sync_edge.sv
// ----------------------------------------------------------------------------
// ov_fifo_wr_ctrl_sync_edge
// Two-flop synchronizer for an asynchronous pin followed by registered
// rise/fall pulse detection.
// Ports: clk, rst (sync, active high), async_in (raw pin),
//        level (synchronized level aligned with the edge pulses),
//        rise / fall (1-cycle pulses).
// A pin change sampled on edge k shows up as a pulse after edge k+2, so the
// consumer acts on edge k+3.
// ----------------------------------------------------------------------------
module ov_fifo_wr_ctrl_sync_edge (
    input  logic clk,
    input  logic rst,
    input  logic async_in,
    output logic level,
    output logic rise,
    output logic fall
);

    logic sync1_r;
    logic sync2_r;
    logic prev_r;
    logic rise_r;
    logic fall_r;

    // Synchronizer chain plus registered edge detection
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_r <= 1'b0;
            sync2_r <= 1'b0;
            prev_r  <= 1'b0;
            rise_r  <= 1'b0;
            fall_r  <= 1'b0;
        end else begin
            sync1_r <= async_in;
            sync2_r <= sync1_r;
            prev_r  <= sync2_r;
            rise_r  <= sync2_r & ~prev_r;
            fall_r  <= ~sync2_r & prev_r;
        end
    end

    // prev_r is the level that the edge pulses refer to, so a decision made
    // on level never disagrees with a pending rise/fall pulse.
    assign level = prev_r;
    assign rise  = rise_r;
    assign fall  = fall_r;

endmodule

// File: rtl/ov_fifo_wr_ctrl.sv
// ----------------------------------------------------------------------------
// ov_fifo_wr_ctrl
// Write-side controller for the OV7670 -> AL422B frame FIFO. Opens the FIFO
// write window for exactly one VSYNC-to-VSYNC frame, pulses the write-pointer
// reset beforehand and reports frame_ready so the reader drains a whole frame.
// Ports: clk (system clock, shared with the read side), rst (sync, active
//        high), bus (ov_fifo_wr_ctrl_if.master: vsync pin, reader handshake,
//        FIFO WEN/WRST and status outputs). All outputs are registered.
// ----------------------------------------------------------------------------
module ov_fifo_wr_ctrl
    import ov_fifo_wr_ctrl_pkg::*;
#(
    parameter int WRST_CYCLES    = WRST_CYCLES_DEF,
    parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF,
    parameter int CNT_W          = CNT_W_DEF
) (
    input  logic               clk,
    input  logic               rst,
    ov_fifo_wr_ctrl_if.master  bus
);

    localparam int WRST_W = (WRST_CYCLES > 1) ? $clog2(WRST_CYCLES) : 1;
    localparam int TO_W   = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [WRST_W-1:0] WRST_LAST = WRST_W'(WRST_CYCLES - 1);
    localparam logic [TO_W-1:0]   TO_LAST   = TO_W'(TIMEOUT_CYCLES - 1);

    wr_state_e          state_r;
    wr_state_e          state_nxt_s;
    logic [WRST_W-1:0]  wrst_cnt_r;
    logic [TO_W-1:0]    to_cnt_r;
    logic [CNT_W-1:0]   frame_cnt_r;
    logic               fifo_wen_r;
    logic               fifo_wrst_r;
    logic               frame_ready_r;
    logic               busy_r;
    logic               timeout_err_r;
    logic               timeout_s;
    logic               to_hit_s;
    logic               vs_level_s;
    logic               vs_rise_s;
    logic               vs_fall_s;

    ov_fifo_wr_ctrl_sync_edge u_vs_sync (
        .clk      (clk),
        .rst      (rst),
        .async_in (bus.ov_vsync),
        .level    (vs_level_s),
        .rise     (vs_rise_s),
        .fall     (vs_fall_s)
    );

    // Next-state decode; a VSYNC edge always wins over a same-cycle timeout
    always_comb begin
        state_nxt_s = state_r;
        timeout_s   = 1'b0;
        to_hit_s    = (to_cnt_r == TO_LAST);
        case (state_r)
            ST_IDLE: begin
                if (bus.frame_req) begin
                    state_nxt_s = ST_ARM;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_ARM: begin
                if (vs_rise_s) begin
                    state_nxt_s = ST_WRST;
                end else if (to_hit_s) begin
                    state_nxt_s = ST_IDLE;
                    timeout_s   = 1'b1;
                end else begin
                    state_nxt_s = ST_ARM;
                end
            end
            ST_WRST: begin
                // Short VSYNC pulses may already be over: skip straight to WRITE
                if (wrst_cnt_r == WRST_LAST) begin
                    if (vs_level_s) begin
                        state_nxt_s = ST_SYNC;
                    end else begin
                        state_nxt_s = ST_WRITE;
                    end
                end else begin
                    state_nxt_s = ST_WRST;
                end
            end
            ST_SYNC: begin
                if (vs_fall_s) begin
                    state_nxt_s = ST_WRITE;
                end else if (to_hit_s) begin
                    state_nxt_s = ST_IDLE;
                    timeout_s   = 1'b1;
                end else begin
                    state_nxt_s = ST_SYNC;
                end
            end
            ST_WRITE: begin
                if (vs_rise_s) begin
                    state_nxt_s = ST_DONE;
                end else if (to_hit_s) begin
                    state_nxt_s = ST_IDLE;
                    timeout_s   = 1'b1;
                end else begin
                    state_nxt_s = ST_WRITE;
                end
            end
            ST_DONE: begin
                if (bus.frame_done) begin
                    if (bus.frame_req) begin
                        state_nxt_s = ST_ARM;
                    end else begin
                        state_nxt_s = ST_IDLE;
                    end
                end else begin
                    state_nxt_s = ST_DONE;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // State register plus WRST pulse and timeout counters (cleared on any state change)
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= ST_IDLE;
            wrst_cnt_r <= '0;
            to_cnt_r   <= '0;
        end else begin
            state_r <= state_nxt_s;
            if (state_nxt_s != state_r) begin
                wrst_cnt_r <= '0;
                to_cnt_r   <= '0;
            end else begin
                if (state_r == ST_WRST) begin
                    wrst_cnt_r <= wrst_cnt_r + WRST_W'(1);
                end
                if (is_timed_state(state_r)) begin
                    to_cnt_r <= to_cnt_r + TO_W'(1);
                end
            end
        end
    end

    // Registered outputs decoded from the next state so they switch with the state
    always_ff @(posedge clk) begin
        if (rst) begin
            fifo_wen_r    <= 1'b0;
            fifo_wrst_r   <= 1'b1;
            frame_ready_r <= 1'b0;
            busy_r        <= 1'b0;
            timeout_err_r <= 1'b0;
            frame_cnt_r   <= '0;
        end else begin
            fifo_wen_r    <= (state_nxt_s == ST_WRITE);
            fifo_wrst_r   <= (state_nxt_s != ST_WRST);
            frame_ready_r <= (state_nxt_s == ST_DONE);
            busy_r        <= (state_nxt_s != ST_IDLE);
            timeout_err_r <= timeout_s;
            if ((state_nxt_s == ST_DONE) && (state_r != ST_DONE)) begin
                frame_cnt_r <= frame_cnt_r + CNT_W'(1);
            end
        end
    end

    assign bus.fifo_wen    = fifo_wen_r;
    assign bus.fifo_wrst   = fifo_wrst_r;
    assign bus.frame_ready = frame_ready_r;
    assign bus.busy        = busy_r;
    assign bus.frame_cnt   = frame_cnt_r;
    assign bus.timeout_err = timeout_err_r;

endmodule

// File: tb/tb_ov_fifo_wr_ctrl.sv
// ----------------------------------------------------------------------------
// tb_ov_fifo_wr_ctrl
// Directed bench for ov_fifo_wr_ctrl. Two instances share clk/rst: dut_a with
// the default timeout (frame capture, reset, wrap) and dut_b with a 1000-cycle
// timeout. A frame-level reference model tracks the VSYNC pin through a
// sample-history line and predicts every output each cycle; hand-computed
// literal checks pin down the key timings.
// ----------------------------------------------------------------------------
module tb_ov_fifo_wr_ctrl;

    localparam int WRST_N = 4;
    localparam int TO_A   = 2_000_000;
    localparam int TO_B   = 1000;

    localparam int M_IDLE  = 0;
    localparam int M_ARM   = 1;
    localparam int M_WRST  = 2;
    localparam int M_SYNC  = 3;
    localparam int M_WRITE = 4;
    localparam int M_DONE  = 5;

    typedef struct {
        int          mode;
        int          age;
        int          left;
        logic [15:0] cnt;
        logic        terr;
        logic [3:0]  h;     // h[i] = pin sampled i+1 edges ago
    } mdl_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_tests = 0;
    int   n_fail  = 0;
    logic chk_en  = 1'b0;
    mdl_t ma;
    mdl_t mb;

    int first_wrst_a, first_wen_a, wrst_lo_a, wen_hi_a;
    int terr_first_b, terr_cnt_b;

    ov_fifo_wr_ctrl_if #(.CNT_W(16)) bus_a ();
    ov_fifo_wr_ctrl_if #(.CNT_W(16)) bus_b ();

    ov_fifo_wr_ctrl #(.WRST_CYCLES(WRST_N), .TIMEOUT_CYCLES(TO_A), .CNT_W(16)) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (bus_a)
    );

    ov_fifo_wr_ctrl #(.WRST_CYCLES(WRST_N), .TIMEOUT_CYCLES(TO_B), .CNT_W(16)) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (bus_b)
    );

    always #5 clk = ~clk;

    // Reference model: one step per rising edge
    task automatic model_step(inout mdl_t m, input logic r, input logic req,
                              input logic done, input logic pin, input int to_cycles);
        int   nxt;
        logic rise, fall, lvl, tmo;
        if (r) begin
            m.mode = M_IDLE; m.age = 0; m.left = 0;
            m.cnt = 16'h0000; m.terr = 1'b0; m.h = 4'h0;
            return;
        end
        // Pin change first sampled 3 edges ago is acted on now
        rise = m.h[2] & ~m.h[3];
        fall = ~m.h[2] & m.h[3];
        lvl  = m.h[2];
        nxt  = m.mode;
        tmo  = 1'b0;
        case (m.mode)
            M_IDLE:  if (req) nxt = M_ARM;
            M_ARM:   if (rise) nxt = M_WRST; else if (m.age == to_cycles - 1) tmo = 1'b1;
            M_WRST:  if (m.left == 1) nxt = lvl ? M_SYNC : M_WRITE;
            M_SYNC:  if (fall) nxt = M_WRITE; else if (m.age == to_cycles - 1) tmo = 1'b1;
            M_WRITE: if (rise) nxt = M_DONE; else if (m.age == to_cycles - 1) tmo = 1'b1;
            M_DONE:  if (done) nxt = req ? M_ARM : M_IDLE;
            default: nxt = M_IDLE;
        endcase
        if (tmo) nxt = M_IDLE;
        m.terr = tmo;
        if (nxt != m.mode) begin
            m.age = 0;
            if (nxt == M_WRST) m.left = WRST_N;
            if (nxt == M_DONE) m.cnt = m.cnt + 16'h0001;
        end else begin
            m.age = m.age + 1;
            if (m.mode == M_WRST) m.left = m.left - 1;
        end
        m.mode = nxt;
        m.h = {m.h[2:0], pin};
    endtask

    function automatic logic [20:0] exp_of(input mdl_t m);
        return {m.mode == M_WRITE, m.mode != M_WRST, m.mode == M_DONE,
                m.mode != M_IDLE, m.cnt, m.terr};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic clear_meas();
        first_wrst_a = -1; first_wen_a = -1; wrst_lo_a = 0; wen_hi_a = 0;
        terr_first_b = -1; terr_cnt_b = 0;
    endtask

    // Model advance on each rising edge
    initial begin
        forever begin
            @(posedge clk);
            cyc++;
            model_step(ma, rst, bus_a.frame_req, bus_a.frame_done, bus_a.ov_vsync, TO_A);
            model_step(mb, rst, bus_b.frame_req, bus_b.frame_done, bus_b.ov_vsync, TO_B);
        end
    end

    // Per-cycle compare against the model, plus timing measurements
    initial begin
        logic [20:0] act;
        forever begin
            @(negedge clk);
            if (chk_en) begin
                act = {bus_a.fifo_wen, bus_a.fifo_wrst, bus_a.frame_ready, bus_a.busy,
                       bus_a.frame_cnt, bus_a.timeout_err};
                n_tests++;
                if (act !== exp_of(ma)) begin
                    n_fail++;
                    if (n_fail <= 20)
                        $display("FAIL cycle_a: cycle %0d got %h, expected %h", cyc, act, exp_of(ma));
                end
                act = {bus_b.fifo_wen, bus_b.fifo_wrst, bus_b.frame_ready, bus_b.busy,
                       bus_b.frame_cnt, bus_b.timeout_err};
                n_tests++;
                if (act !== exp_of(mb)) begin
                    n_fail++;
                    if (n_fail <= 20)
                        $display("FAIL cycle_b: cycle %0d got %h, expected %h", cyc, act, exp_of(mb));
                end
            end
            if (bus_a.fifo_wrst === 1'b0) begin
                wrst_lo_a++;
                if (first_wrst_a < 0) first_wrst_a = cyc;
            end
            if (bus_a.fifo_wen === 1'b1) begin
                wen_hi_a++;
                if (first_wen_a < 0) first_wen_a = cyc;
            end
            if (bus_b.timeout_err === 1'b1) begin
                terr_cnt_b++;
                if (terr_first_b < 0) terr_first_b = cyc;
            end
        end
    end

    // Directed stimulus
    initial begin
        int t_a, t_f, t_q;
        bus_a.ov_vsync = 1'b0; bus_a.frame_req = 1'b0; bus_a.frame_done = 1'b0;
        bus_b.ov_vsync = 1'b0; bus_b.frame_req = 1'b0; bus_b.frame_done = 1'b0;
        clear_meas();
        rst = 1'b1;
        tick(3);
        check("rst_wen",   {31'd0, bus_a.fifo_wen},    32'd0);
        check("rst_wrst",  {31'd0, bus_a.fifo_wrst},   32'd1);
        check("rst_ready", {31'd0, bus_a.frame_ready}, 32'd0);
        check("rst_busy",  {31'd0, bus_a.busy},        32'd0);
        check("rst_cnt",   {16'd0, bus_a.frame_cnt},   32'd0);
        rst = 1'b0;
        chk_en = 1'b1;
        tick(2);

        // Full frame through the SYNC path: VSYNC high 100, low 10000, high
        clear_meas();
        bus_a.frame_req = 1'b1;
        tick(5);
        t_a = cyc + 1; bus_a.ov_vsync = 1'b1; tick(100);
        t_f = cyc + 1; bus_a.ov_vsync = 1'b0; tick(10000);
        bus_a.ov_vsync = 1'b1; tick(10);
        check("t2_wrst_start", first_wrst_a, t_a + 3);
        check("t2_wrst_len",   wrst_lo_a, 32'd4);
        check("t2_wen_start",  first_wen_a, t_f + 3);
        check("t2_wen_len",    wen_hi_a, 32'd10000);
        check("t2_ready",      {31'd0, bus_a.frame_ready}, 32'd1);
        check("t2_cnt",        {16'd0, bus_a.frame_cnt}, 32'd1);

        // frame_done with frame_req held -> re-arm; short 3-cycle VSYNC
        bus_a.frame_done = 1'b1; tick(1); bus_a.frame_done = 1'b0;
        check("t4_rearm_ready", {31'd0, bus_a.frame_ready}, 32'd0);
        check("t4_rearm_busy",  {31'd0, bus_a.busy}, 32'd1);
        clear_meas();
        bus_a.ov_vsync = 1'b0; tick(20);
        t_a = cyc + 1; bus_a.ov_vsync = 1'b1; tick(3);
        bus_a.ov_vsync = 1'b0; tick(50);
        check("t3_wrst_len",  wrst_lo_a, 32'd4);
        check("t3_wen_start", first_wen_a, t_a + 7);
        bus_a.ov_vsync = 1'b1; tick(10);
        check("t3_cnt", {16'd0, bus_a.frame_cnt}, 32'd2);
        bus_a.frame_req = 1'b0;
        bus_a.frame_done = 1'b1; tick(1); bus_a.frame_done = 1'b0;
        check("t4_idle_busy",  {31'd0, bus_a.busy}, 32'd0);
        check("t4_idle_ready", {31'd0, bus_a.frame_ready}, 32'd0);
        tick(5);

        // Reset in the middle of a write window
        bus_a.frame_req = 1'b1;
        bus_a.ov_vsync = 1'b0; tick(10);
        bus_a.ov_vsync = 1'b1; tick(5);
        bus_a.ov_vsync = 1'b0; tick(30);
        check("t1_in_write", {31'd0, bus_a.fifo_wen}, 32'd1);
        rst = 1'b1; bus_a.frame_req = 1'b0; tick(1); rst = 1'b0;
        check("t1_wen",  {31'd0, bus_a.fifo_wen}, 32'd0);
        check("t1_wrst", {31'd0, bus_a.fifo_wrst}, 32'd1);
        check("t1_cnt",  {16'd0, bus_a.frame_cnt}, 32'd0);
        check("t1_busy", {31'd0, bus_a.busy}, 32'd0);
        tick(5);

        // Counter wrap: preload FFFF during WRITE, finish the frame
        bus_a.frame_req = 1'b1; tick(2);
        bus_a.ov_vsync = 1'b1; tick(20);
        bus_a.ov_vsync = 1'b0; tick(20);
        chk_en = 1'b0;
        ma.cnt = 16'hFFFF;
        force dut_a.frame_cnt_r = 16'hFFFF;
        tick(1);
        release dut_a.frame_cnt_r;
        tick(1);
        chk_en = 1'b1;
        check("t6_preload", {16'd0, bus_a.frame_cnt}, 32'h0000FFFF);
        bus_a.ov_vsync = 1'b1; tick(10);
        check("t6_wrap",  {16'd0, bus_a.frame_cnt}, 32'h00000000);
        check("t6_ready", {31'd0, bus_a.frame_ready}, 32'd1);
        bus_a.frame_req = 1'b0;
        bus_a.frame_done = 1'b1; tick(1); bus_a.frame_done = 1'b0;
        tick(5);

        // Timeout on dut_b: no VSYNC at all, stray frame_done pulses
        clear_meas();
        t_q = cyc + 1; bus_b.frame_req = 1'b1; tick(1); bus_b.frame_req = 1'b0;
        tick(100);
        bus_b.frame_done = 1'b1; tick(1); bus_b.frame_done = 1'b0;
        tick(400);
        bus_b.frame_done = 1'b1; tick(1); bus_b.frame_done = 1'b0;
        tick(600);
        check("t5_terr_cycle", terr_first_b, t_q + 1000);
        check("t5_terr_width", terr_cnt_b, 32'd1);
        check("t5_busy",       {31'd0, bus_b.busy}, 32'd0);
        check("t5_cnt",        {16'd0, bus_b.frame_cnt}, 32'd0);
        check("t5_wen",        {31'd0, bus_b.fifo_wen}, 32'd0);

        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
